// File: rtl/mcpu_ctrl_pkg.sv
// mcpu_ctrl_pkg: opcodes, state encoding and datapath select constants for the multicycle MIPS control
package mcpu_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_R_EXEC   = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_I_EXEC   = 4'd9;
  localparam logic [3:0] S_I_WB     = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OPC   = 2'b11;
  typedef struct packed {
    logic mem;
    logic rtype;
    logic branch;
    logic itype;
    logic jump;
    logic illegal;
  } op_class_t;
endpackage

// File: rtl/ctrl_opclass.sv
// ctrl_opclass: classifies an opcode into one-hot instruction classes plus a logical-immediate flag
module ctrl_opclass
  import mcpu_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opcode,
  output op_class_t      cls,
  output logic           is_logic_imm
);
  // exactly one class bit is set; anything unrecognised lands in illegal
  always_comb begin
    cls = '0;
    cls.mem = opcode == OP_LW || opcode == OP_SW;
    cls.rtype = opcode == OP_RTYPE;
    cls.branch = opcode == OP_BEQ || opcode == OP_BNE;
    cls.itype = opcode == OP_ADDI || opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_SLTI;
    cls.jump = opcode == OP_J;
    cls.illegal = ~(cls.mem | cls.rtype | cls.branch | cls.itype | cls.jump);
    is_logic_imm = opcode == OP_ANDI || opcode == OP_ORI;
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main multicycle MIPS control FSM; IMM_ZERO_EXT_EN enables zero-extension for andi/ori
module multicycle_ctrl
  import mcpu_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           alu_zero,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           mem_write,
  output logic           i_or_d,
  output logic           ir_write,
  output logic           pc_en,
  output logic [1:0]     pc_source,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic           ext_zero,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           reg_write,
  output logic           illegal_op,
  output logic [STW-1:0] state_o
);
`ifdef IMM_ZERO_EXT_EN
  localparam logic ZEXT = 1'b1;
`else
  localparam logic ZEXT = 1'b0;
`endif
  logic [STW-1:0] state, next;
  op_class_t cls;
  logic logic_imm;
  ctrl_opclass #(.OPW(OPW)) u_opclass (
    .opcode      (opcode),
    .cls         (cls),
    .is_logic_imm(logic_imm)
  );
  assign state_o = state;
  // state register
  always_ff @(posedge clk)
    state <= rst ? S_FETCH : next;
  // next-state: memory states wait on mem_ready, decode dispatches on opcode class
  always_comb begin
    next = S_FETCH;
    case (state)
      S_FETCH:    next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   next = cls.mem ? S_MEM_ADDR : cls.rtype ? S_R_EXEC : cls.branch ? S_BRANCH :
                         cls.itype ? S_I_EXEC : cls.jump ? S_JUMP : S_FETCH;
      S_MEM_ADDR: next = opcode == OP_LW ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   next = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   next = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   next = S_R_WB;
      S_I_EXEC:   next = S_I_WB;
      default:    next = S_FETCH;
    endcase
  end
  // datapath controls decoded from the registered state; all forced low during reset
  always_comb begin
    mem_req = 1'b0;
    mem_write = 1'b0;
    i_or_d = 1'b0;
    ir_write = 1'b0;
    pc_en = 1'b0;
    pc_source = PC_ALU;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_B;
    alu_op = ALU_ADD;
    ext_zero = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    reg_write = 1'b0;
    illegal_op = 1'b0;
    if (!rst)
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write = mem_ready;
          pc_en = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH;
          ext_zero = ZEXT & logic_imm;
          illegal_op = cls.illegal;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          i_or_d = 1'b1;
        end
        S_MEM_WB: begin
          reg_write = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_write = 1'b1;
          i_or_d = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op = ALU_FUNCT;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op = ALU_SUB;
          pc_source = PC_ALUOUT;
          pc_en = opcode == OP_BEQ ? alu_zero : ~alu_zero;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op = ALU_OPC;
          ext_zero = ZEXT & logic_imm;
        end
        S_I_WB: reg_write = 1'b1;
        S_JUMP: begin
          pc_source = PC_JUMP;
          pc_en = 1'b1;
        end
        default: ;
      endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction stream checked against an instruction-level reference model
module tb_multicycle_ctrl;
  typedef struct packed {
    logic       mem_req, mem_write, i_or_d, ir_write, pc_en;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       ext_zero, reg_dst, mem_to_reg, reg_write, illegal_op;
  } outs_t;
`ifdef IMM_ZERO_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, alu_zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic mem_req, mem_write, i_or_d, ir_write, pc_en, alu_src_a, ext_zero, reg_dst, mem_to_reg, reg_write, illegal_op;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state_o;
  outs_t outs;
  int n_cmp = 0, n_err = 0;
  assign outs = {mem_req, mem_write, i_or_d, ir_write, pc_en, pc_source, alu_src_a, alu_src_b, alu_op,
                 ext_zero, reg_dst, mem_to_reg, reg_write, illegal_op};
  always #5 clk = ~clk;
  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write), .pc_en(pc_en),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .ext_zero(ext_zero), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal_op(illegal_op), .state_o(state_o)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic outs_t model_outs(int s, logic [5:0] op, logic z, logic mr);
    outs_t o = '0;
    bit limm = op == 6'b001100 || op == 6'b001101;
    bit legal = op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                           6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000010};
    case (s)
      0: begin o.mem_req = 1; o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_en = mr; end
      1: begin o.alu_src_b = 2'b11; o.ext_zero = EXT && limm; o.illegal_op = !legal; end
      2: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      3: begin o.mem_req = 1; o.i_or_d = 1; end
      4: begin o.reg_write = 1; o.mem_to_reg = 1; end
      5: begin o.mem_req = 1; o.mem_write = 1; o.i_or_d = 1; end
      6: begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      7: begin o.reg_write = 1; o.reg_dst = 1; end
      8: begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_source = 2'b01; o.pc_en = op == 6'b000100 ? z : !z; end
      9: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 2'b11; o.ext_zero = EXT && limm; end
      10: o.reg_write = 1;
      11: begin o.pc_source = 2'b10; o.pc_en = 1; end
      default: ;
    endcase
    return o;
  endfunction
  // one instruction from FETCH back to FETCH; fst/mst = cycles mem_ready stays low in fetch / data access
  task automatic run_instr(logic [5:0] op, logic z, int fst, int mst);
    int q[$];
    int m = 0, cyc = 0, exp_cpi;
    bit left = 0, done = 0;
    bit is_mem = op == 6'b100011 || op == 6'b101011;
    case (op)
      6'b100011: q = '{1, 2, 3, 4};
      6'b101011: q = '{1, 2, 5};
      6'b000000: q = '{1, 6, 7};
      6'b000100, 6'b000101: q = '{1, 8};
      6'b001000, 6'b001100, 6'b001101, 6'b001010: q = '{1, 9, 10};
      6'b000010: q = '{1, 11};
      default: q = '{1};
    endcase
    exp_cpi = q.size() + 1 + fst + (is_mem ? mst : 0);
    for (int c = 0; c < 60 && !done; c++) begin
      opcode = op;
      alu_zero = m == 8 ? z : 1'($urandom);
      if (m == 0) begin
        mem_ready = fst == 0;
        if (fst > 0) fst--;
      end else if (m == 3 || m == 5) begin
        mem_ready = mst == 0;
        if (mst > 0) mst--;
      end else mem_ready = 1'($urandom);
      #1;
      check($sformatf("outs s%0d op%02h", m, op), 32'(outs), 32'(model_outs(m, op, alu_zero, mem_ready)));
      check($sformatf("state op%02h", op), 32'(state_o), 32'(m));
      left |= state_o != 4'd0;
      cyc++;
      if (!((m == 0 || m == 3 || m == 5) && !mem_ready)) m = q.size() > 0 ? q.pop_front() : 0;
      tick;
      done = left && state_o == 4'd0;
    end
    check($sformatf("timeout op%02h", op), 32'(done), 32'd1);
    check($sformatf("cpi op%02h", op), 32'(cyc), 32'(exp_cpi));
  endtask
  localparam logic [5:0] LEGAL [10] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                                        6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b000010};
  initial begin
    mem_ready = 1'b1;
    tick;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_outs", 32'(outs), 32'd0);
    tick;
    rst = 1'b0;
    opcode = 6'b100011;
    #1;
    check("fetch_req", 32'({mem_req, i_or_d}), 32'b10);
    tick;
    tick;
    tick;
    mem_ready = 1'b0;
    #1;
    check("stall_state", 32'(state_o), 32'd3);
    check("stall_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("rst_abandon_outs", 32'(outs), 32'd0);
    check("rst_abandon_state", 32'(state_o), 32'd3);
    tick;
    check("rst_hold_state", 32'(state_o), 32'd0);
    check("rst_hold_outs", 32'(outs), 32'd0);
    tick;
    rst = 1'b0;
    #1;
    check("post_rst_state", 32'(state_o), 32'd0);
    check("post_rst_req", 32'({mem_req, i_or_d}), 32'b10);
    run_instr(6'b100011, 0, 0, 0);
    run_instr(6'b101011, 0, 0, 3);
    run_instr(6'b000100, 1, 0, 0);
    run_instr(6'b000101, 1, 0, 0);
    run_instr(6'b000100, 0, 1, 0);
    run_instr(6'b000101, 0, 0, 0);
    run_instr(6'b001101, 0, 0, 0);
    run_instr(6'b111111, 0, 0, 0);
    run_instr(6'b100011, 0, 2, 2);
    for (int i = 0; i < 200; i++)
      run_instr($urandom_range(0, 3) == 0 ? 6'($urandom) : LEGAL[$urandom_range(0, 9)],
                1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences fetch, decode, execute, memory and writeback over 3–5 cycles per instruction.
- Drives every datapath mux select and write enable, including the immediate extender (sign/zero select), ALU source muxes, PC update and register file writes.
- Stalls on a memory ready handshake.

Parameters:
- OPW, 6, opcode field width.
- STW, 4, state register width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- alu_zero  in  1  ALU zero flag, valid in BRANCH
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request active
- mem_write  out  1  request is a write (valid with mem_req)
- i_or_d  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  latch instruction register
- pc_en  out  1  PC register load enable
- pc_source  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = extended imm, 11 = extended imm << 2
- alu_op  out  2  00 add, 01 sub, 10 use funct field, 11 use opcode (I-type ALU)
- ext_zero  out  1  extender mode: 1 = zero-extend, 0 = sign-extend
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- illegal_op  out  1  one-cycle pulse on an unknown opcode
- state_o  out  4  current state, for debug

Behaviour:
- Reset
  - Clock is clk; reset is rst, synchronous, active-high.
  - rst sampled high: state <= FETCH.
  - While rst is high, every output is forced to 0, except state_o, which shows the register value.
- Outputs
  - Combinational decode of the registered state; the only input terms are mem_ready, alu_zero and opcode, as listed below.
  - Any output not named for a state is 0.
- States and transitions (one state per cycle unless stalled):
  - FETCH (0)
    - Outputs: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
    - When mem_ready=1: ir_write=1, pc_en=1, go to DECODE. Otherwise stay.
  - DECODE (1)
    - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target).
    - Next state by opcode:
      - 100011 lw, 101011 sw → MEM_ADDR
      - 000000 R-type → R_EXEC
      - 000100 beq, 000101 bne → BRANCH
      - 001000 addi, 001100 andi, 001101 ori, 001010 slti → I_EXEC
      - 000010 j → JUMP
      - any other opcode → illegal_op=1, go to FETCH
  - MEM_ADDR (2)
    - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
    - lw → MEM_RD; sw → MEM_WR.
  - MEM_RD (3)
    - Outputs: mem_req=1, i_or_d=1.
    - Stay until mem_ready=1, then go to MEM_WB.
  - MEM_WB (4)
    - Outputs: reg_write=1, mem_to_reg=1, reg_dst=0.
    - Next: FETCH.
  - MEM_WR (5)
    - Outputs: mem_req=1, mem_write=1, i_or_d=1.
    - Stay until mem_ready=1, then go to FETCH.
  - R_EXEC (6)
    - Outputs: alu_src_a=1, alu_src_b=00, alu_op=10.
    - Next: R_WB.
  - R_WB (7)
    - Outputs: reg_write=1, reg_dst=1, mem_to_reg=0.
    - Next: FETCH.
  - BRANCH (8)
    - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01.
    - pc_en = alu_zero for beq, ~alu_zero for bne.
    - Next: FETCH.
  - I_EXEC (9)
    - Outputs: alu_src_a=1, alu_src_b=10, alu_op=11.
    - Next: I_WB.
  - I_WB (10)
    - Outputs: reg_write=1, reg_dst=0, mem_to_reg=0.
    - Next: FETCH.
  - JUMP (11)
    - Outputs: pc_source=10, pc_en=1.
    - Next: FETCH.
  - Encodings 12–15: next state FETCH, outputs 0.
- Cycles per instruction (mem_ready=1 on first request): lw 5; sw, R-type, I-type 4; beq, bne, j 3.
- Stall: in FETCH, MEM_RD and MEM_WR, mem_req stays high and all other outputs hold until mem_ready=1.
- Event ordering:
  - mem_ready=1 outside FETCH, MEM_RD or MEM_WR is ignored.
  - rst asserted mid-stall abandons the request: mem_req=0 in the same cycle, FETCH on the next edge.
- opcode is sampled only in DECODE, MEM_ADDR, BRANCH and I_EXEC; the IR is stable there.

Optional Feature:
- Macro: IMM_ZERO_EXT_EN.
- Defined: ext_zero=1 in DECODE and I_EXEC when opcode is andi (001100) or ori (001101); 0 otherwise. Logical immediates are zero-extended.
- Undefined: ext_zero is tied to 0; every immediate is sign-extended. andi and ori still execute, using the sign-extended immediate.

Decomposition:
- Package mcpu_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J);
  - the state encoding constants S_FETCH..S_JUMP;
  - the pc_source, alu_src_b and alu_op select constants.
- One sub-module is natural: ctrl_opclass.
  - Purely combinational: opcode in; one-hot class out (mem, rtype, branch, itype, jump, illegal) plus an is_logic_imm flag.
  - Reused by the next-state logic and by the ext_zero logic.

Test Plan:
- Reset: rst=1 for 2 cycles during a MEM_RD stall → mem_req=0 immediately; state_o=0 after release; the first FETCH issues mem_req=1 with i_or_d=0.
- lw, opcode 100011, mem_ready=1 always → states 0,1,2,3,4; exactly 5 cycles; reg_write=1 and mem_to_reg=1 only in state 4.
- sw with mem_ready held low 3 cycles in MEM_WR → mem_req=1 and mem_write=1 for 4 cycles; no reg_write; then FETCH.
- beq with alu_zero=1 → pc_en=1 and pc_source=01 in BRANCH. bne with alu_zero=1 → pc_en=0. Each takes 3 cycles.
- ori, opcode 001101 → ext_zero=1 in DECODE and I_EXEC with IMM_ZERO_EXT_EN defined, 0 without; alu_op=11 and alu_src_b=10 in I_EXEC; reg_dst=0 in I_WB.
- Opcode 111111 in DECODE → illegal_op=1 for exactly 1 cycle; next state FETCH; no write enables asserted.
